mrr_mf_es_ctrl: RTL and testbench
=================================

MRR_MF_ES_CTRL -- requirements
Module: mrr_mf_es_ctrl

Interface
REQ-001 SHALL have parameter MF_MAX_N_LOG2, default 4: width of the accumulator-count setting.
REQ-002 SHALL have parameter MF_MAX_M_LOG2, default 7: width of the accum-length-log2 setting.
REQ-003 SHALL have parameter ES_WIDTH, default 9: width of the Es input.
REQ-004 SHALL have parameter MF_PIPE_LAT, default 2: enabled samples between the MF input and valid Es.
REQ-005 SHALL have parameter HOLDOFF, default 8: consecutive non-increasing Es samples that end a peak.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  one input sample this cycle; forwarded as mf_enable.
- cfg_num_accum  in  MF_MAX_N_LOG2  requested N.
- cfg_accum_len_log2  in  MF_MAX_M_LOG2  requested log2(M).
- cfg_threshold  in  ES_WIDTH  detection threshold.
- start  in  1  pulse; latch cfg_* and begin.
- stop  in  1  pulse; return to IDLE.
- continuous  in  1  1 = re-arm after each report.
- es  in  ES_WIDTH  Es from the energy estimator.
- mf_num_accum  out  MF_MAX_N_LOG2  registered N.
- mf_accum_len_log2  out  MF_MAX_M_LOG2  registered log2(M).
- mf_settings_changed  out  1  one-cycle clear pulse to the estimator.
- mf_enable  out  1  equals sample_en (combinational).
- busy  out  1  state != IDLE.
- cfg_err  out  1  sticky; last start was rejected.
- det_valid  out  1  one-cycle detection pulse.
- det_peak  out  ES_WIDTH  peak Es of the reported detection.
- det_offset  out  16  enabled samples from the end of WARMUP to the peak sample.

Function
REQ-007 SHALL implement states IDLE, APPLY, WARMUP, SEARCH, TRACK, REPORT.
REQ-008 SHALL, in IDLE on start, reject the start if cfg_num_accum < 2 or cfg_accum_len_log2 > 7: set cfg_err and stay in IDLE; otherwise clear cfg_err, latch the cfg_* values into the mf_* outputs and an internal threshold, then go to APPLY.
REQ-009 SHALL, in APPLY, assert mf_settings_changed for exactly one cycle, then go to WARMUP.
REQ-010 SHALL, in WARMUP, count enabled samples from 0 and go to SEARCH on the sample where count = N*2^L + MF_PIPE_LAT - 1.
REQ-011 SHALL size the warm-up counter at 16 bits, with no overflow for the maximum N=15, L=7 (terminal count 1921).
REQ-012 SHALL hold the offset counter at 0 on WARMUP exit, increment it per enabled sample, and saturate it at 0xFFFF.
REQ-013 SHALL, in SEARCH, on an enabled sample with es >= threshold, load peak = es, load peak_offset = offset counter, clear the holdoff counter, and go to TRACK.
REQ-014 SHALL, in TRACK on each enabled sample: if es > peak, update peak and peak_offset and clear holdoff; otherwise increment holdoff.
REQ-015 SHALL, in TRACK, go to REPORT when holdoff reaches HOLDOFF or when es < threshold.
REQ-016 SHALL, in REPORT, pulse det_valid for one cycle with det_peak/det_offset valid that cycle, then go to SEARCH if continuous=1, else to IDLE.
REQ-017 SHALL hold det_peak and det_offset stable until the next report.
REQ-018 SHALL ignore samples in all states while sample_en=0; no counter advances.
REQ-019 SHALL, on stop in any state other than IDLE, go to IDLE next cycle with no det_valid; stop wins over any simultaneous transition, including REPORT.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL ignore start and stop asserted together in IDLE, leaving cfg_err unchanged.
REQ-022 SHALL leave mf_* outputs unchanged except in the cycle a start is accepted.
REQ-023 SHALL treat es exactly equal to threshold as a crossing.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force: state IDLE, mf_num_accum=0, mf_accum_len_log2=0, mf_settings_changed=0, busy=0, cfg_err=0, det_valid=0, det_peak=0, det_offset=0, all counters 0.
REQ-025 SHALL release reset synchronously to clk and ignore start on the first cycle after deassertion.
REQ-026 SHALL, on reset mid-operation, abandon any in-progress detection with no det_valid.

Verification
REQ-027 Config accept: start with N=4, L=3, threshold=100 -> mf_settings_changed high exactly one cycle after APPLY entry; SEARCH entered on the 34th enabled sample (4*8+2).
REQ-028 Reject: start with N=1 or L=9 -> cfg_err=1, busy=0, no mf_settings_changed; next valid start clears cfg_err.
REQ-029 Peak via holdoff: in SEARCH, es = 50,120,180,200,190 then 8 samples <=200 and >=100 -> one det_valid with det_peak=200 and det_offset equal to the offset of the 200 sample.
REQ-030 Peak via threshold drop: continuous=1, es = 150, then 40 -> det_valid with det_peak=150; SEARCH re-entered; a second crossing gives a second report.
REQ-031 Stop/reset: stop in TRACK, and separately rst_n low in WARMUP -> IDLE, no det_valid, all outputs at reset values (reset case).
REQ-032 Gapped samples: sample_en toggling 1/0 throughout -> warm-up and offset counts identical to the contiguous case.

Source files
------------

// File: rtl/mrr_mf_es_ctrl.sv
// Matched-filter / energy-estimator sequencer: applies accumulator settings,
// waits out the filter warm-up, then searches for and reports Es peaks.
module mrr_mf_es_ctrl #(
    parameter int MF_MAX_N_LOG2 = 4,
    parameter int MF_MAX_M_LOG2 = 7,
    parameter int ES_WIDTH      = 9,
    parameter int MF_PIPE_LAT   = 2,
    parameter int HOLDOFF       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic [MF_MAX_N_LOG2-1:0] cfg_num_accum,
    input  logic [MF_MAX_M_LOG2-1:0] cfg_accum_len_log2,
    input  logic [ES_WIDTH-1:0]      cfg_threshold,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     continuous,
    input  logic [ES_WIDTH-1:0]      es,
    output logic [MF_MAX_N_LOG2-1:0] mf_num_accum,
    output logic [MF_MAX_M_LOG2-1:0] mf_accum_len_log2,
    output logic                     mf_settings_changed,
    output logic                     mf_enable,
    output logic                     busy,
    output logic                     cfg_err,
    output logic                     det_valid,
    output logic [ES_WIDTH-1:0]      det_peak,
    output logic [15:0]              det_offset
);

    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HW:0] HOLD_TC = HOLDOFF[HW:0];

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        WARMUP = 3'd2,
        SEARCH = 3'd3,
        TRACK  = 3'd4,
        REPORT = 3'd5
    } state_t;

    state_t                   state_reg, state_next;
    logic                     rst_done_reg;
    logic [ES_WIDTH-1:0]      thr_reg;
    logic [MF_MAX_N_LOG2-1:0] num_reg;
    logic [MF_MAX_M_LOG2-1:0] len_reg;
    logic                     cfg_err_reg;
    logic [15:0]              warm_cnt_reg;
    logic [15:0]              off_cnt_reg;
    logic [HW-1:0]            hold_cnt_reg;
    logic [ES_WIDTH-1:0]      peak_reg;
    logic [15:0]              peak_off_reg;
    logic [ES_WIDTH-1:0]      held_peak_reg;
    logic [15:0]              held_off_reg;

    logic        start_ok;
    logic        cfg_bad;
    logic [15:0] warm_term;
    logic        warm_done;
    logic        es_cross;
    logic        es_rise;
    logic [HW:0] hold_inc;
    logic        hold_last;
    logic        report_fire;

    // Start is only honoured once the first clock after reset release has passed.
    assign start_ok  = start && !stop && rst_done_reg;
    assign cfg_bad   = (32'(cfg_num_accum) < 32'd2) || (32'(cfg_accum_len_log2) > 32'd7);
    assign warm_term = (16'(num_reg) << len_reg) + 16'(MF_PIPE_LAT) - 16'd1;
    assign warm_done = sample_en && (warm_cnt_reg == warm_term);
    assign es_cross  = (es >= thr_reg);
    assign es_rise   = (es > peak_reg);
    assign hold_inc  = {1'b0, hold_cnt_reg} + 1'b1;
    assign hold_last = (hold_inc >= HOLD_TC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_next = state_reg;
        if (stop && (state_reg != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start_ok && !cfg_bad) state_next = APPLY;
                APPLY:   state_next = WARMUP;
                WARMUP:  if (warm_done) state_next = SEARCH;
                SEARCH:  if (sample_en && es_cross) state_next = TRACK;
                TRACK: begin
                    if (sample_en && (!es_cross || (!es_rise && hold_last)))
                        state_next = REPORT;
                end
                REPORT:  state_next = continuous ? SEARCH : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        report_fire         = (state_reg == REPORT) && !stop;
        busy                = (state_reg != IDLE);
        mf_settings_changed = (state_reg == APPLY);
        mf_enable           = sample_en;
        mf_num_accum        = num_reg;
        mf_accum_len_log2   = len_reg;
        cfg_err             = cfg_err_reg;
        det_valid           = report_fire;
        det_peak            = report_fire ? peak_reg     : held_peak_reg;
        det_offset          = report_fire ? peak_off_reg : held_off_reg;
    end

    // Configuration latch and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_reg <= 1'b0;
            num_reg      <= '0;
            len_reg      <= '0;
            thr_reg      <= '0;
            cfg_err_reg  <= 1'b0;
        end else begin
            rst_done_reg <= 1'b1;
            if ((state_reg == IDLE) && start_ok) begin
                cfg_err_reg <= cfg_bad;
                if (!cfg_bad) begin
                    num_reg <= cfg_num_accum;
                    len_reg <= cfg_accum_len_log2;
                    thr_reg <= cfg_threshold;
                end
            end
        end
    end

    // Warm-up and offset counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_reg <= '0;
            off_cnt_reg  <= '0;
        end else begin
            if ((state_reg == WARMUP) && (state_next == WARMUP)) begin
                if (sample_en) warm_cnt_reg <= warm_cnt_reg + 16'd1;
            end else begin
                warm_cnt_reg <= '0;
            end

            if ((state_reg == WARMUP) || (state_next == IDLE)) begin
                off_cnt_reg <= '0;
            end else if (sample_en && (off_cnt_reg != 16'hFFFF) &&
                         ((state_reg == SEARCH) || (state_reg == TRACK) ||
                          (state_reg == REPORT))) begin
                off_cnt_reg <= off_cnt_reg + 16'd1;
            end
        end
    end

    // Peak tracking and holdoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_reg     <= '0;
            peak_off_reg <= '0;
            hold_cnt_reg <= '0;
        end else if ((state_reg == SEARCH) && sample_en && es_cross) begin
            peak_reg     <= es;
            peak_off_reg <= off_cnt_reg;
            hold_cnt_reg <= '0;
        end else if ((state_reg == TRACK) && sample_en) begin
            if (es_rise) begin
                peak_reg     <= es;
                peak_off_reg <= off_cnt_reg;
                hold_cnt_reg <= '0;
            end else begin
                hold_cnt_reg <= hold_inc[HW-1:0];
            end
        end
    end

    // Reported values persist between reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_peak_reg <= '0;
            held_off_reg  <= '0;
        end else if (report_fire) begin
            held_peak_reg <= peak_reg;
            held_off_reg  <= peak_off_reg;
        end
    end

endmodule

// File: tb/tb_mrr_mf_es_ctrl.sv
// Scenario-driven bench for mrr_mf_es_ctrl: expected detections are queued as
// stimulus is driven and matched when det_valid pulses.
module tb_mrr_mf_es_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [3:0]  cfg_num_accum = '0;
    logic [6:0]  cfg_accum_len_log2 = '0;
    logic [8:0]  cfg_threshold = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [8:0]  es = '0;
    logic [3:0]  mf_num_accum;
    logic [6:0]  mf_accum_len_log2;
    logic        mf_settings_changed;
    logic        mf_enable;
    logic        busy;
    logic        cfg_err;
    logic        det_valid;
    logic [8:0]  det_peak;
    logic [15:0] det_offset;

    int total = 0;
    int bad = 0;
    int sc_count = 0;

    typedef struct packed {
        logic [8:0]  peak;
        logic [15:0] off;
    } exp_t;
    exp_t sb[$];

    mrr_mf_es_ctrl dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
        .cfg_num_accum(cfg_num_accum), .cfg_accum_len_log2(cfg_accum_len_log2),
        .cfg_threshold(cfg_threshold), .start(start), .stop(stop),
        .continuous(continuous), .es(es), .mf_num_accum(mf_num_accum),
        .mf_accum_len_log2(mf_accum_len_log2), .mf_settings_changed(mf_settings_changed),
        .mf_enable(mf_enable), .busy(busy), .cfg_err(cfg_err), .det_valid(det_valid),
        .det_peak(det_peak), .det_offset(det_offset)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every det_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mf_settings_changed) sc_count++;
        if (det_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL det_unexpected: got peak=%0d offset=%0d, none expected", det_peak, det_offset);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (det_peak !== e.peak || det_offset !== e.off) begin
                    bad++;
                    $display("FAIL det_match: got peak=%0d offset=%0d, want peak=%0d offset=%0d",
                             det_peak, det_offset, e.peak, e.off);
                end else begin
                    $display("det ok: peak=%0d offset=%0d", det_peak, det_offset);
                end
            end
        end
    end

    task automatic cyc(input logic en, input logic [8:0] e);
        sample_en = en;
        es = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n, input logic [6:0] l, input logic [8:0] thr);
        cfg_num_accum = n;
        cfg_accum_len_log2 = l;
        cfg_threshold = thr;
        start = 1'b1;
        sample_en = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("start n=%0d l=%0d thr=%0d -> busy=%0d cfg_err=%0d", n, l, thr, busy, cfg_err);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, cfg_err, det_valid, mf_settings_changed, mf_num_accum, mf_accum_len_log2, det_peak, det_offset} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0d err=%0d n=%0d l=%0d peak=%0d off=%0d, want all 0",
                     busy, cfg_err, mf_num_accum, mf_accum_len_log2, det_peak, det_offset);
        end
        rst_n = 1'b1;
        do_start(4'd4, 7'd3, 9'd100);   // first cycle after release: must be ignored
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_after_reset: got busy=%0d, want 0", busy);
        end
        sample_en = 1'b1;
        #1;
        total++;
        if (mf_enable !== 1'b1) begin
            bad++;
            $display("FAIL mf_enable: got %0d, want 1", mf_enable);
        end
        sample_en = 1'b0;
        #1;
    endtask

    task automatic test_config_accept;
        int sc0;
        sc0 = sc_count;
        do_start(4'd4, 7'd3, 9'd100);
        total++;
        if (mf_settings_changed !== 1'b1 || busy !== 1'b1 || mf_num_accum !== 4'd4 ||
            mf_accum_len_log2 !== 7'd3 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL apply: got chg=%0d busy=%0d n=%0d l=%0d err=%0d, want 1 1 4 3 0",
                     mf_settings_changed, busy, mf_num_accum, mf_accum_len_log2, cfg_err);
        end
        cyc(1'b0, 9'd0);
        total++;
        if (mf_settings_changed !== 1'b0 || sc_count != sc0 + 1) begin
            bad++;
            $display("FAIL apply_pulse: got chg=%0d pulses=%0d, want 0 and 1", mf_settings_changed, sc_count - sc0);
        end
        // Above-threshold Es during warm-up would be caught if SEARCH began early.
        for (int i = 0; i < 34; i++) cyc(1'b1, 9'd250);
    endtask

    task automatic test_peak_holdoff;
        logic [8:0] seq [13] = '{9'd50, 9'd120, 9'd180, 9'd200, 9'd190, 9'd150, 9'd160,
                                 9'd170, 9'd180, 9'd190, 9'd200, 9'd110, 9'd100};
        continuous = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) sb.push_back('{peak: 9'd200, off: 16'd3});
            cyc(1'b1, seq[i]);
        end
        cyc(1'b0, 9'd0);
        cyc(1'b0, 9'd0);
        total++;
        if (busy !== 1'b0 || det_peak !== 9'd200 || det_offset !== 16'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL holdoff_end: got busy=%0d peak=%0d off=%0d pending=%0d, want 0 200 3 0",
                     busy, det_peak, det_offset, sb.size());
        end
    endtask

    task automatic test_reject;
        int sc0;
        sc0 = sc_count;
        do_start(4'd1, 7'd3, 9'd100);
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || mf_num_accum !== 4'd4) begin
            bad++;
            $display("FAIL reject_n: got err=%0d busy=%0d n=%0d, want 1 0 4", cfg_err, busy, mf_num_accum);
        end
        do_start(4'd4, 7'd9, 9'd100);
        cyc(1'b0, 9'd0);
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || mf_accum_len_log2 !== 7'd3 || sc_count != sc0) begin
            bad++;
            $display("FAIL reject_l: got err=%0d busy=%0d l=%0d pulses=%0d, want 1 0 3 0",
                     cfg_err, busy, mf_accum_len_log2, sc_count - sc0);
        end
        stop = 1'b1;
        do_start(4'd2, 7'd0, 9'd100);
        stop = 1'b0;
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_stop_idle: got err=%0d busy=%0d, want 1 0", cfg_err, busy);
        end
        do_start(4'd2, 7'd0, 9'd100);
        total++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reject_clear: got err=%0d busy=%0d, want 0 1", cfg_err, busy);
        end
        stop = 1'b1;
        cyc(1'b0, 9'd0);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_apply: got busy=%0d, want 0", busy);
        end
    endtask

    task automatic test_threshold_drop;
        continuous = 1'b1;
        do_start(4'd2, 7'd0, 9'd100);
        cyc(1'b0, 9'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 9'd0);
        sb.push_back('{peak: 9'd150, off: 16'd0});
        cyc(1'b1, 9'd150);
        cyc(1'b1, 9'd40);
        cyc(1'b0, 9'd0);
        total++;
        if (busy !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL rearm: got busy=%0d pending=%0d, want 1 0", busy, sb.size());
        end
        cyc(1'b1, 9'd30);
        sb.push_back('{peak: 9'd100, off: 16'd3});   // Es equal to threshold is a crossing
        cyc(1'b1, 9'd100);
        cyc(1'b1, 9'd90);
        cyc(1'b0, 9'd0);
        cyc(1'b1, 9'd200);
        cyc(1'b1, 9'd50);
        stop = 1'b1;                                  // stop in REPORT suppresses the pulse
        cyc(1'b0, 9'd0);
        stop = 1'b0;
        continuous = 1'b0;
        total++;
        if (busy !== 1'b0 || det_peak !== 9'd100 || det_offset !== 16'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL stop_report: got busy=%0d peak=%0d off=%0d pending=%0d, want 0 100 3 0",
                     busy, det_peak, det_offset, sb.size());
        end
    endtask

    task automatic test_stop_reset;
        do_start(4'd2, 7'd0, 9'd100);
        cyc(1'b0, 9'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 9'd0);
        cyc(1'b1, 9'd150);
        stop = 1'b1;
        cyc(1'b1, 9'd20);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_track: got busy=%0d, want 0", busy);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 9'd20);
        do_start(4'd2, 7'd0, 9'd100);
        cyc(1'b0, 9'd0);
        cyc(1'b1, 9'd0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, cfg_err, det_valid, mf_settings_changed, mf_num_accum, mf_accum_len_log2, det_peak, det_offset} !== '0) begin
            bad++;
            $display("FAIL reset_warmup: got busy=%0d n=%0d l=%0d peak=%0d off=%0d, want all 0",
                     busy, mf_num_accum, mf_accum_len_log2, det_peak, det_offset);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 9'd0);
        cyc(1'b0, 9'd0);
    endtask

    task automatic test_gapped;
        logic [8:0] seq [13] = '{9'd50, 9'd120, 9'd180, 9'd200, 9'd190, 9'd150, 9'd160,
                                 9'd170, 9'd180, 9'd190, 9'd200, 9'd110, 9'd100};
        do_start(4'd4, 7'd3, 9'd100);
        cyc(1'b0, 9'd0);
        for (int i = 0; i < 34; i++) begin
            cyc(1'b1, 9'd250);
            cyc(1'b0, 9'd255);
        end
        for (int i = 0; i < 13; i++) begin
            if (i == 3) sb.push_back('{peak: 9'd200, off: 16'd3});
            cyc(1'b1, seq[i]);
            cyc(1'b0, 9'd255);
        end
        cyc(1'b0, 9'd0);
        total++;
        if (busy !== 1'b0 || det_offset !== 16'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL gapped: got busy=%0d off=%0d pending=%0d, want 0 3 0", busy, det_offset, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_config_accept();
        test_peak_holdoff();
        test_reject();
        test_threshold_drop();
        test_stop_reset();
        test_gapped();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL pending_reports: got %0d outstanding, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
